// File: rtl/jk_ctrl_pkg.sv
// Shared constants for the JK counter controller and its cell bank.
// Optional interrupt flag is enabled by defining JK_CTRL_IRQ_EN.
package jk_ctrl_pkg;

    localparam logic [1:0] OP_STOP = 2'b00;
    localparam logic [1:0] OP_LOAD = 2'b01;
    localparam logic [1:0] OP_UP   = 2'b10;
    localparam logic [1:0] OP_DOWN = 2'b11;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] UP   = 2'd2;
    localparam logic [1:0] DOWN = 2'd3;

    localparam logic [1:0] JK_HOLD   = 2'b00;
    localparam logic [1:0] JK_RESET  = 2'b01;
    localparam logic [1:0] JK_SET    = 2'b10;
    localparam logic [1:0] JK_TOGGLE = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop cell: 00 hold, 01 reset, 10 set, 11 toggle.
// Asynchronous active-high reset clears q.
module jk_cell
    import jk_ctrl_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic j,
    input  logic k,
    output logic q,
    output logic qn
);

    logic q_q;

    // JK state update
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_q <= 1'b0;
        end else begin
            unique case ({j, k})
                JK_HOLD:   q_q <= q_q;
                JK_RESET:  q_q <= 1'b0;
                JK_SET:    q_q <= 1'b1;
                JK_TOGGLE: q_q <= ~q_q;
            endcase
        end
    end

    assign q  = q_q;
    assign qn = ~q_q;

endmodule

// File: rtl/jk_counter_ctrl.sv
// Command sequencer driving a bank of JK cells as a loadable up/down counter.
// Define JK_CTRL_IRQ_EN to add the sticky irq flag and its irq_clr input.
module jk_counter_ctrl
    import jk_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             tc
`ifdef JK_CTRL_IRQ_EN
    ,
    input  logic             irq_clr,
    output logic             irq
`endif
);

    logic [1:0]       state_q, state_d;
    // Holds LIM while counting and the load value while in LOAD; a RUN
    // always recaptures it, so sharing one register is invisible outside.
    logic [WIDTH-1:0] lim_q, lim_d;
    logic             tc_q;
    logic             accept;
    logic             wrap;
    logic [WIDTH-1:0] step_nxt;
    logic [WIDTH-1:0] step_mask;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic [WIDTH-1:0] unused_qn;

    assign cmd_ready = (state_q != LOAD);
    assign busy      = (state_q == UP) || (state_q == DOWN);
    assign accept    = cmd_valid & cmd_ready;
    assign tc        = tc_q;

    // Next count value and wrap detection for the counting states
    always_comb begin
        wrap     = 1'b0;
        step_nxt = count;
        unique case (state_q)
            UP: begin
                wrap     = (count >= lim_q);
                step_nxt = wrap ? '0 : count + 1'b1;
            end
            DOWN: begin
                wrap     = (count == '0);
                step_nxt = wrap ? lim_q : count - 1'b1;
            end
            default: ;
        endcase
    end

    assign step_mask = count ^ step_nxt;

    // Per-cell J/K drive: SET/RESET to load, TOGGLE changed bits when counting
    always_comb begin
        logic [1:0] jk;
        cell_j = '0;
        cell_k = '0;
        for (int i = 0; i < WIDTH; i++) begin
            unique case (state_q)
                LOAD:     jk = lim_q[i] ? JK_SET : JK_RESET;
                UP, DOWN: jk = step_mask[i] ? JK_TOGGLE : JK_HOLD;
                default:  jk = JK_HOLD;
            endcase
            cell_j[i] = jk[1];
            cell_k[i] = jk[0];
        end
    end

    // Command decode and state transitions
    always_comb begin
        state_d = state_q;
        lim_d   = lim_q;
        if (state_q == LOAD) begin
            state_d = IDLE;
        end else if (accept) begin
            unique case (cmd_op)
                OP_STOP: state_d = IDLE;
                OP_LOAD: begin
                    if (state_q == IDLE) begin
                        state_d = LOAD;
                        lim_d   = cmd_data;
                    end
                end
                OP_UP: begin
                    state_d = UP;
                    lim_d   = cmd_data;
                end
                OP_DOWN: begin
                    state_d = DOWN;
                    lim_d   = cmd_data;
                end
            endcase
        end
    end

    // Controller registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            lim_q   <= '0;
            tc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            lim_q   <= lim_d;
            tc_q    <= wrap;
        end
    end

`ifdef JK_CTRL_IRQ_EN
    logic irq_q, irq_d;

    // Sticky flag: a wrap sets it even when a clear arrives together
    always_comb begin
        irq_d = irq_q;
        if (wrap)
            irq_d = 1'b1;
        else if (irq_clr)
            irq_d = 1'b0;
    end

    // Interrupt flag register
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_q <= 1'b0;
        else
            irq_q <= irq_d;
    end

    assign irq = irq_q;
`endif

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        jk_cell u_cell (
            .clk (clk),
            .rst (rst),
            .j   (cell_j[i]),
            .k   (cell_k[i]),
            .q   (count[i]),
            .qn  (unused_qn[i])
        );
    end

endmodule

// File: tb/tb_jk_counter_ctrl.sv
// Directed bench for jk_counter_ctrl with a cycle-level reference model.
// Irq checks are included when JK_CTRL_IRQ_EN is defined.
module tb_jk_counter_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data;
    logic [3:0] count;
    logic       busy;
    logic       tc;
`ifdef JK_CTRL_IRQ_EN
    logic       irq_clr;
    logic       irq;
`endif

    int total = 0;
    int bad   = 0;

    // model: st 0 idle, 1 load, 2 up, 3 down
    int m_st  = 0;
    int m_cnt = 0;
    int m_lim = 0;
    int m_ld  = 0;
    int m_tc  = 0;
    int m_irq = 0;

    int up_seq[7] = '{1, 2, 3, 4, 5, 0, 1};
    int dn_seq[4] = '{1, 0, 9, 8};
    int fr_seq[3] = '{15, 0, 1};

    always #5 clk = ~clk;

    jk_counter_ctrl #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_data  (cmd_data),
        .count     (count),
        .busy      (busy),
        .tc        (tc)
`ifdef JK_CTRL_IRQ_EN
        ,
        .irq_clr   (irq_clr),
        .irq       (irq)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int step(int st, int c, int l);
        if (st == 2) return (c >= l) ? 0 : (c + 1) % 16;
        if (st == 3) return (c == 0) ? l : c - 1;
        return c;
    endfunction

    function automatic int wraps(int st, int c, int l);
        return ((st == 2 && c >= l) || (st == 3 && c == 0)) ? 1 : 0;
    endfunction

    function automatic int exp_j(int st, int c, int l, int ld);
        if (st == 1) return ld;
        if (st >= 2) return c ^ step(st, c, l);
        return 0;
    endfunction

    function automatic int exp_k(int st, int c, int l, int ld);
        if (st == 1) return (~ld) & 15;
        if (st >= 2) return c ^ step(st, c, l);
        return 0;
    endfunction

    // Reference model
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_st  <= 0;
            m_cnt <= 0;
            m_lim <= 0;
            m_ld  <= 0;
            m_tc  <= 0;
            m_irq <= 0;
        end else begin
            m_tc  <= wraps(m_st, m_cnt, m_lim);
            m_cnt <= (m_st == 1) ? m_ld : step(m_st, m_cnt, m_lim);
`ifdef JK_CTRL_IRQ_EN
            if (wraps(m_st, m_cnt, m_lim) != 0)
                m_irq <= 1;
            else if (irq_clr)
                m_irq <= 0;
`endif
            if (m_st == 1) begin
                m_st <= 0;
            end else if (cmd_valid) begin
                case (cmd_op)
                    2'd0: m_st <= 0;
                    2'd1: begin
                        if (m_st == 0) begin
                            m_st <= 1;
                            m_ld <= int'(cmd_data);
                        end
                    end
                    2'd2: begin
                        m_st  <= 2;
                        m_lim <= int'(cmd_data);
                    end
                    default: begin
                        m_st  <= 3;
                        m_lim <= int'(cmd_data);
                    end
                endcase
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        if (!rst) begin
            chk("count", count, m_cnt);
            chk("tc", tc, m_tc);
            chk("busy", busy, (m_st >= 2) ? 1 : 0);
            chk("ready", cmd_ready, (m_st != 1) ? 1 : 0);
            chk("cell_j", dut.cell_j, exp_j(m_st, m_cnt, m_lim, m_ld));
            chk("cell_k", dut.cell_k, exp_k(m_st, m_cnt, m_lim, m_ld));
`ifdef JK_CTRL_IRQ_EN
            chk("irq", irq, m_irq);
`endif
        end
    end

    task automatic send(input logic [1:0] op, input logic [3:0] d);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = d;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        cmd_valid = 1'b0;
        cmd_op    = 2'd0;
        cmd_data  = 4'd0;
`ifdef JK_CTRL_IRQ_EN
        irq_clr   = 1'b0;
`endif
        #2;
        chk("rst_count", count, 0);
        chk("rst_tc", tc, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // load 0xA
        send(2'd1, 4'hA);
        chk("load_ready", cmd_ready, 0);
        chk("load_j", dut.cell_j, 4'b1010);
        chk("load_k", dut.cell_k, 4'b0101);
        @(negedge clk);
        chk("load_count", count, 4'hA);
        chk("load_ready_back", cmd_ready, 1);

        // count up, LIM=5
        send(2'd1, 4'd0);
        @(negedge clk);
        send(2'd2, 4'd5);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            chk("up5_count", count, up_seq[i]);
            chk("up5_tc", tc, (up_seq[i] == 0) ? 1 : 0);
        end

        // load 2, count down, LIM=9
        send(2'd0, 4'd0);
        send(2'd1, 4'd2);
        @(negedge clk);
        chk("load2_count", count, 2);
        send(2'd3, 4'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("dn9_count", count, dn_seq[i]);
            chk("dn9_tc", tc, (dn_seq[i] == 9) ? 1 : 0);
        end

        // stop lands on 3 and holds
        send(2'd0, 4'd0);
        send(2'd1, 4'd0);
        @(negedge clk);
        send(2'd2, 4'd7);
        @(negedge clk);
        @(negedge clk);
        chk("pre_stop_count", count, 2);
        send(2'd0, 4'd0);
        chk("stop_busy", busy, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stop_hold", count, 3);
        end

        // LIM=0 up: pinned at 0 with tc every cycle
        send(2'd2, 4'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("lim0_count", count, 0);
            chk("lim0_tc", tc, 1);
        end

        // full range wrap 14,15,0,1
        send(2'd0, 4'd0);
        send(2'd1, 4'hE);
        @(negedge clk);
        send(2'd2, 4'hF);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_count", count, fr_seq[i]);
            chk("full_tc", tc, (fr_seq[i] == 0) ? 1 : 0);
        end

        // reset mid-count at 3
        @(negedge clk);
        @(negedge clk);
        chk("pre_rst_count", count, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst_count", count, 0);
        chk("midrst_tc", tc, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_ready", cmd_ready, 1);
        @(negedge clk);
        rst = 1'b0;

        // LIM=0 down: 0 -> 0 with tc every cycle
        send(2'd3, 4'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("dn0_count", count, 0);
            chk("dn0_tc", tc, 1);
        end
        send(2'd0, 4'd0);

`ifdef JK_CTRL_IRQ_EN
        irq_clr = 1'b1;
        send(2'd1, 4'd0);
        irq_clr = 1'b0;
        chk("irq_cleared", irq, 0);
        @(negedge clk);
        send(2'd2, 4'd1);
        @(negedge clk);
        chk("irq_quiet", irq, 0);
        @(negedge clk);
        chk("irq_set", irq, 1);
        irq_clr = 1'b1;
        @(negedge clk);
        chk("irq_clr", irq, 0);
        @(negedge clk);
        chk("irq_set_wins", irq, 1);
        chk("irq_set_wins_tc", tc, 1);
        irq_clr = 1'b0;
        send(2'd0, 4'd0);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
